// File: rtl/simple_bus_responder.sv
// Responder end of the simple command bus: runs WRITE/COPY/SWAP/CLEAR/ADD
// against a small word-addressed register file and answers with a done pulse.
module simple_bus_responder #(
  parameter int AW       = 4,
  parameter int WAIT_CYC = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [3:0]    cmd,
  input  logic [15:0]   saddr,
  input  logic [15:0]   daddr,
  output logic          done,
  output logic          err,
  output logic          busy,
  output logic          ovf,
  input  logic [AW-1:0] dbg_addr,
  output logic [15:0]   dbg_data
);

  localparam int DEPTH = 2 ** AW;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RD   = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_WR   = 2'd3;

  localparam logic [3:0] CMD_NOP   = 4'd0;
  localparam logic [3:0] CMD_WRITE = 4'd1;
  localparam logic [3:0] CMD_COPY  = 4'd2;
  localparam logic [3:0] CMD_SWAP  = 4'd3;
  localparam logic [3:0] CMD_CLEAR = 4'd4;
  localparam logic [3:0] CMD_ADD   = 4'd5;

  localparam logic [3:0] WAIT_LAST = (WAIT_CYC > 0) ? 4'(WAIT_CYC - 1) : 4'd0;

  logic [1:0]    state;
  logic [3:0]    wait_cnt;
  logic [3:0]    cmd_q;
  logic [15:0]   saddr_q;
  logic [15:0]   daddr_q;
  logic [15:0]   a_q;
  logic [15:0]   b_q;
  logic          fail_q;
  logic [15:0]   mem [DEPTH];

  logic [AW-1:0] s_idx;
  logic [AW-1:0] d_idx;
  logic          s_out_of_range;
  logic          d_out_of_range;
  logic          cmd_error;
  logic          wr_active;

  assign s_idx          = saddr_q[AW-1:0];
  assign d_idx          = daddr_q[AW-1:0];
  assign s_out_of_range = |(saddr_q >> AW);
  assign d_out_of_range = |(daddr_q >> AW);
  assign wr_active      = (state == S_WR) && !fail_q;
  assign dbg_data       = mem[dbg_addr];

  // saddr is data for WRITE, so it is only range-checked where it addresses memory.
  // NOTE: every variable assigned in always_comb gets a default first, so no path leaves it unassigned and infers a latch.
  always_comb begin
    cmd_error = 1'b0;
    case (cmd_q)
      CMD_NOP:   cmd_error = 1'b0;
      CMD_WRITE,
      CMD_CLEAR: cmd_error = d_out_of_range;
      CMD_COPY,
      CMD_SWAP,
      CMD_ADD:   cmd_error = d_out_of_range || s_out_of_range;
      default:   cmd_error = 1'b1;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values, whatever the statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
      cmd_q    <= '0;
      saddr_q  <= '0;
      daddr_q  <= '0;
      a_q      <= '0;
      b_q      <= '0;
      fail_q   <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      busy     <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      // The done cycle is back in IDLE, so a strobe there is an acceptance, not an overrun.
      if (en && (state != S_IDLE)) ovf <= 1'b1;
      case (state)
        S_IDLE: begin
          busy <= en;
          if (en) begin
            cmd_q   <= cmd;
            saddr_q <= saddr;
            daddr_q <= daddr;
            state   <= S_RD;
          end
        end
        S_RD: begin
          a_q      <= mem[s_idx];
          b_q      <= mem[d_idx];
          fail_q   <= cmd_error;
          wait_cnt <= '0;
          state    <= (WAIT_CYC == 0) ? S_WR : S_WAIT;
        end
        S_WAIT: begin
          wait_cnt <= wait_cnt + 4'd1;
          if (wait_cnt == WAIT_LAST) state <= S_WR;
        end
        S_WR: begin
          done  <= 1'b1;
          err   <= fail_q;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // SWAP with saddr==daddr issues two writes of the same value to one word, leaving it unchanged.
  // NOTE: the register file is small and must read as zero after reset, so it sits on the async reset like any other flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_active) begin
      case (cmd_q)
        CMD_WRITE: mem[d_idx] <= saddr_q;
        CMD_COPY:  mem[d_idx] <= a_q;
        CMD_SWAP: begin
          mem[d_idx] <= a_q;
          mem[s_idx] <= b_q;
        end
        CMD_CLEAR: mem[d_idx] <= '0;
        CMD_ADD:   mem[d_idx] <= a_q + b_q;
        default: ;
      endcase
    end
  end

endmodule
